// File: rtl/banked_memory_controller_pkg.sv
// Shared encodings for the banked memory controller: funct3 access sizes, fault codes,
// FSM states and the latched request payload.
package banked_memory_controller_pkg;

  localparam logic [2:0] LOAD_B   = 3'b000;
  localparam logic [2:0] LOAD_H   = 3'b001;
  localparam logic [2:0] LOAD_W   = 3'b010;
  localparam logic [2:0] LOAD_BU  = 3'b100;
  localparam logic [2:0] LOAD_HU  = 3'b101;
  localparam logic [2:0] STORE_B  = 3'b000;
  localparam logic [2:0] STORE_H  = 3'b001;
  localparam logic [2:0] STORE_W  = 3'b010;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'b00,
    FAULT_UNMAPPED   = 2'b01,
    FAULT_MISALIGNED = 2'b10,
    FAULT_ROM_WRITE  = 2'b11
  } fault_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  typedef struct packed {
    logic        write;
    logic [2:0]  size_and_sign;
    logic [31:0] write_data;
  } req_t;

  // Illegal size code for the direction, or natural alignment violated.
  function automatic logic size_illegal(input logic write, input logic [2:0] size,
                                        input logic [1:0] lane);
    logic bad;
    bad = 1'b1;
    case (size)
      LOAD_B:  bad = 1'b0;
      LOAD_H:  bad = lane[0];
      LOAD_W:  bad = |lane;
      LOAD_BU: bad = write;
      LOAD_HU: bad = write | lane[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/banked_memory_controller_ram_bank.sv
// Word-organised RAM with per-byte write enables and combinational read.
module ram_bank #(
  parameter int unsigned WORDS = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata_c
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata_c = mem[addr];

endmodule

// File: rtl/banked_memory_controller.sv
// Single-outstanding request/response port in front of a ROM region and a byte-writable
// RAM region, with programmable access latency and fault reporting.
module banked_memory_controller
  import banked_memory_controller_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]  ROM_BASE       = ADDR_WIDTH'(32'h0000_0000),
  parameter int unsigned            ROM_WORDS      = 128,
  parameter logic [ADDR_WIDTH-1:0]  RAM_BASE       = ADDR_WIDTH'(32'h0000_1000),
  parameter int unsigned            RAM_WORDS      = 256,
  parameter int unsigned            ACCESS_LATENCY = 1,
  parameter logic [31:0]            ROM_IMAGE [ROM_WORDS] = '{default: 32'h0}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [2:0]            req_size_and_sign,
  input  logic [31:0]           req_write_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_read_data,
  output logic                  resp_fault,
  output logic [1:0]            resp_fault_code
);

  localparam int unsigned ROM_AW = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;
  localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned CNT_W  = $clog2(ACCESS_LATENCY + 1);
  localparam logic [ADDR_WIDTH:0] ROM_END =
    {1'b0, ROM_BASE} + (ADDR_WIDTH+1)'(4 * ROM_WORDS);
  localparam logic [ADDR_WIDTH:0] RAM_END =
    {1'b0, RAM_BASE} + (ADDR_WIDTH+1)'(4 * RAM_WORDS);

  state_e                  state_q, state_d;
  req_t                    req_q, req_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    req_ready_d, resp_valid_d, resp_fault_d;
  logic [31:0]             resp_read_data_d;
  logic [1:0]              resp_fault_code_d;

  logic                    rom_hit_c, ram_hit_c;
  logic [ROM_AW-1:0]       rom_idx_c;
  logic [RAM_AW-1:0]       ram_idx_c;
  logic [1:0]              lane_c;
  fault_e                  fault_c;
  logic [31:0]             word_c, ram_rdata_c, load_c, ram_wdata_c;
  logic [7:0]              byte_c;
  logic [15:0]             half_c;
  logic [3:0]              ram_be_c;
  logic                    ram_we_c, access_c;

  // Region decode on the latched address.
  assign rom_hit_c = ({1'b0, addr_q} >= {1'b0, ROM_BASE}) && ({1'b0, addr_q} < ROM_END);
  assign ram_hit_c = ({1'b0, addr_q} >= {1'b0, RAM_BASE}) && ({1'b0, addr_q} < RAM_END);
  assign rom_idx_c = ROM_AW'((addr_q - ROM_BASE) >> 2);
  assign ram_idx_c = RAM_AW'((addr_q - RAM_BASE) >> 2);
  assign lane_c    = addr_q[1:0];

  always_comb begin
    fault_c = FAULT_NONE;
    if (size_illegal(req_q.write, req_q.size_and_sign, lane_c)) fault_c = FAULT_MISALIGNED;
    else if (!rom_hit_c && !ram_hit_c)                          fault_c = FAULT_UNMAPPED;
    else if (req_q.write && rom_hit_c)                          fault_c = FAULT_ROM_WRITE;
  end

  // Load path: lane select then extension.
  assign word_c = rom_hit_c ? ROM_IMAGE[rom_idx_c] : ram_rdata_c;
  assign byte_c = word_c[{lane_c, 3'b000} +: 8];
  assign half_c = word_c[{lane_c[1], 4'b0000} +: 16];

  always_comb begin
    load_c = '0;
    case (req_q.size_and_sign)
      LOAD_B:  load_c = {{24{byte_c[7]}}, byte_c};
      LOAD_BU: load_c = {24'h0, byte_c};
      LOAD_H:  load_c = {{16{half_c[15]}}, half_c};
      LOAD_HU: load_c = {16'h0, half_c};
      LOAD_W:  load_c = word_c;
      default: load_c = '0;
    endcase
  end

  // Store path: replicate data across lanes, enable only the addressed ones.
  always_comb begin
    ram_wdata_c = req_q.write_data;
    ram_be_c    = 4'b0000;
    case (req_q.size_and_sign)
      STORE_B: begin
        ram_wdata_c = {4{req_q.write_data[7:0]}};
        ram_be_c    = 4'b0001 << lane_c;
      end
      STORE_H: begin
        ram_wdata_c = {2{req_q.write_data[15:0]}};
        ram_be_c    = lane_c[1] ? 4'b1100 : 4'b0011;
      end
      STORE_W: ram_be_c = 4'b1111;
      default: ram_be_c = 4'b0000;
    endcase
  end

  assign access_c = (state_q == ST_WAIT) && (cnt_q == '0);
  assign ram_we_c = access_c && req_q.write && (fault_c == FAULT_NONE);

  ram_bank #(
    .WORDS (RAM_WORDS),
    .AW    (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we_c),
    .addr    (ram_idx_c),
    .be      (ram_be_c),
    .wdata   (ram_wdata_c),
    .rdata_c (ram_rdata_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d           = state_q;
    req_d             = req_q;
    addr_d            = addr_q;
    cnt_d             = cnt_q;
    req_ready_d       = req_ready;
    resp_valid_d      = resp_valid;
    resp_read_data_d  = resp_read_data;
    resp_fault_d      = resp_fault;
    resp_fault_code_d = resp_fault_code;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          req_d       = '{write: req_write, size_and_sign: req_size_and_sign,
                          write_data: req_write_data};
          addr_d      = req_address;
          cnt_d       = CNT_W'(ACCESS_LATENCY - 1);
          req_ready_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (access_c) begin
          resp_valid_d      = 1'b1;
          resp_fault_d      = (fault_c != FAULT_NONE);
          resp_fault_code_d = fault_c;
          resp_read_data_d  = (fault_c != FAULT_NONE || req_q.write) ? 32'h0 : load_c;
          state_d           = ST_RESPOND;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESPOND: begin
        if (resp_ready) begin
          resp_valid_d      = 1'b0;
          resp_read_data_d  = '0;
          resp_fault_d      = 1'b0;
          resp_fault_code_d = FAULT_NONE;
          req_ready_d       = 1'b1;
          state_d           = ST_IDLE;
        end
      end
      default: begin
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      req_q           <= '0;
      addr_q          <= '0;
      cnt_q           <= '0;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_read_data  <= '0;
      resp_fault      <= 1'b0;
      resp_fault_code <= FAULT_NONE;
    end else begin
      state_q         <= state_d;
      req_q           <= req_d;
      addr_q          <= addr_d;
      cnt_q           <= cnt_d;
      req_ready       <= req_ready_d;
      resp_valid      <= resp_valid_d;
      resp_read_data  <= resp_read_data_d;
      resp_fault      <= resp_fault_d;
      resp_fault_code <= resp_fault_code_d;
    end
  end

endmodule

// File: tb/tb_banked_memory_controller.sv
// Bench for banked_memory_controller: two instances (latency 1 and 3) checked every cycle
// against an address-map/byte-array model of the memory.
module tb_banked_memory_controller;

  localparam logic [31:0] TB_ROM [128] = '{0: 32'hDEAD_BEEF, 1: 32'h8001_7F80,
                                            127: 32'h0BAD_C0DE, default: 32'h0};

  logic        clk, reset_n;
  logic [1:0]  req_valid, req_ready, req_write, resp_valid, resp_ready, resp_fault;
  logic [31:0] req_address [2];
  logic [31:0] req_write_data [2];
  logic [31:0] resp_read_data [2];
  logic [2:0]  req_size_and_sign [2];
  logic [1:0]  resp_fault_code [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    banked_memory_controller #(
      .ACCESS_LATENCY ((g == 0) ? 1 : 3),
      .ROM_IMAGE      (TB_ROM)
    ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .req_valid         (req_valid[g]),
      .req_ready         (req_ready[g]),
      .req_write         (req_write[g]),
      .req_address       (req_address[g]),
      .req_size_and_sign (req_size_and_sign[g]),
      .req_write_data    (req_write_data[g]),
      .resp_valid        (resp_valid[g]),
      .resp_ready        (resp_ready[g]),
      .resp_read_data    (resp_read_data[g]),
      .resp_fault        (resp_fault[g]),
      .resp_fault_code   (resp_fault_code[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;
  bit   [1:0]  busy = '0;
  bit   [1:0]  exp_on = '0;
  logic [31:0] exp_data [2];
  logic [1:0]  exp_code [2];
  logic [31:0] ram_m [2][256];

  task automatic chk(input int d, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %h, required %h", name, d, $time, act, exp);
    end
  endtask

  // Reference: byte-level view of the address map.
  task automatic model(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] fc);
    bit          in_rom, in_ram, ok_size;
    int          nbytes, lane, idx;
    logic [31:0] word, mask;
    in_rom  = (a < 32'h200);
    in_ram  = (a >= 32'h1000) && (a < 32'h1400);
    nbytes  = 1 << int'(sz[1:0]);
    ok_size = wr ? (sz inside {3'd0, 3'd1, 3'd2}) : (sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    lane    = int'(a[1:0]);
    rd      = 32'h0;
    if (!ok_size || (lane % nbytes) != 0) fc = 2'b10;
    else if (!in_rom && !in_ram)          fc = 2'b01;
    else if (wr && in_rom)                fc = 2'b11;
    else                                  fc = 2'b00;
    if (fc == 2'b00) begin
      idx  = in_rom ? int'(a >> 2) : int'((a - 32'h1000) >> 2);
      word = in_rom ? TB_ROM[idx] : ram_m[d][idx];
      if (wr) begin
        for (int i = 0; i < nbytes; i++) word[8*(lane+i) +: 8] = wd[8*i +: 8];
        ram_m[d][idx] = word;
      end else begin
        word = word >> (8 * lane);
        if (nbytes < 4) begin
          mask = (32'd1 << (8 * nbytes)) - 32'd1;
          word = word & mask;
          if (!sz[2] && word[8*nbytes-1]) word = word | ~mask;
        end
        rd = word;
      end
    end
  endtask

  // Every-cycle check of both instances against the expected handshake state.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk(d, "req_ready", 32'(req_ready[d]), 32'(!busy[d]));
        chk(d, "resp_valid", 32'(resp_valid[d]), 32'(exp_on[d]));
        if (exp_on[d]) begin
          chk(d, "resp_read_data", resp_read_data[d], exp_data[d]);
          chk(d, "resp_fault", 32'(resp_fault[d]), 32'(exp_code[d] != 2'b00));
          chk(d, "resp_fault_code", 32'(resp_fault_code[d]), 32'(exp_code[d]));
        end
      end
    end
  end

  // One complete transaction; called just after a rising edge with the instance idle.
  task automatic txn(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] wd, input int stall, input bit poke, input bit lit,
                     input logic [31:0] lit_d, input logic [1:0] lit_c);
    logic [31:0] md;
    logic [1:0]  mc;
    int          lat;
    lat = (d == 0) ? 1 : 3;
    model(d, wr, a, sz, wd, md, mc);
    if (lit) begin
      chk(d, "model_data", md, lit_d);
      chk(d, "model_code", 32'(mc), 32'(lit_c));
    end
    req_write[d] = wr; req_address[d] = a; req_size_and_sign[d] = sz;
    req_write_data[d] = wd; req_valid[d] = 1'b1;
    @(posedge clk); #1;
    busy[d] = 1'b1;
    req_valid[d] = 1'b0;
    req_write[d] = 1'b1; req_address[d] = 32'h0000_1000;
    req_size_and_sign[d] = 3'b010; req_write_data[d] = 32'hBAD0_BAD0;
    for (int k = 1; k < lat; k++) begin
      req_valid[d] = poke;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    exp_data[d] = md; exp_code[d] = mc; exp_on[d] = 1'b1;
    repeat (stall) begin
      req_valid[d] = poke;
      @(posedge clk); #1;
    end
    req_valid[d] = 1'b0;
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    exp_on[d] = 1'b0;
    busy[d] = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1;
    req_valid = '0; req_write = '0; resp_ready = '0;
    for (int d = 0; d < 2; d++) begin
      req_address[d] = '0; req_write_data[d] = '0; req_size_and_sign[d] = '0;
      exp_data[d] = '0; exp_code[d] = '0;
    end
    #2 reset_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst_req_ready", 32'(req_ready[d]), 32'd1);
      chk(d, "rst_resp_valid", 32'(resp_valid[d]), 32'd0);
      chk(d, "rst_read_data", resp_read_data[d], 32'h0);
      chk(d, "rst_fault", 32'(resp_fault[d]), 32'd0);
      chk(d, "rst_fault_code", 32'(resp_fault_code[d]), 32'd0);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Latency-1 instance: ROM, byte/half paths, faults, boundaries.
    txn(0, 0, 32'h0000_0000, 3'b010, 32'h0, 0, 0, 1, 32'hDEAD_BEEF, 2'b00);
    txn(0, 1, 32'h0000_1000, 3'b010, 32'h1122_3344, 0, 0, 1, 32'h0, 2'b00);
    txn(0, 1, 32'h0000_1004, 3'b010, 32'hA5A5_A5A5, 0, 0, 0, 32'h0, 2'b00);
    txn(0, 1, 32'h0000_13FC, 3'b010, 32'h0BAD_F00D, 0, 0, 0, 32'h0, 2'b00);
    txn(0, 1, 32'h0000_1003, 3'b000, 32'h0000_0080, 0, 0, 1, 32'h0, 2'b00);
    txn(0, 0, 32'h0000_1003, 3'b000, 32'h0, 0, 0, 1, 32'hFFFF_FF80, 2'b00);
    txn(0, 0, 32'h0000_1003, 3'b100, 32'h0, 0, 0, 1, 32'h0000_0080, 2'b00);
    txn(0, 0, 32'h0000_1000, 3'b010, 32'h0, 2, 0, 1, 32'h8022_3344, 2'b00);
    txn(0, 1, 32'h0000_1002, 3'b001, 32'h0000_8001, 0, 0, 0, 32'h0, 2'b00);
    txn(0, 0, 32'h0000_1002, 3'b001, 32'h0, 0, 0, 1, 32'hFFFF_8001, 2'b00);
    txn(0, 0, 32'h0000_1002, 3'b101, 32'h0, 0, 0, 1, 32'h0000_8001, 2'b00);
    txn(0, 0, 32'h0000_1000, 3'b010, 32'h0, 0, 0, 1, 32'h8001_3344, 2'b00);
    txn(0, 0, 32'h0000_1001, 3'b001, 32'h0, 0, 0, 1, 32'h0, 2'b10);
    txn(0, 0, 32'h0000_1002, 3'b010, 32'h0, 0, 0, 1, 32'h0, 2'b10);
    txn(0, 1, 32'h0000_0000, 3'b010, 32'hFFFF_FFFF, 0, 0, 1, 32'h0, 2'b11);
    txn(0, 0, 32'h0000_0000, 3'b010, 32'h0, 0, 0, 1, 32'hDEAD_BEEF, 2'b00);
    txn(0, 0, 32'h0000_3000, 3'b010, 32'h0, 0, 0, 1, 32'h0, 2'b01);
    txn(0, 0, 32'h0000_1000, 3'b011, 32'h0, 0, 0, 1, 32'h0, 2'b10);
    txn(0, 1, 32'h0000_0001, 3'b001, 32'h0, 0, 0, 1, 32'h0, 2'b10);
    txn(0, 1, 32'h0000_1000, 3'b100, 32'h0, 0, 0, 1, 32'h0, 2'b10);
    txn(0, 0, 32'h0000_0005, 3'b000, 32'h0, 0, 0, 1, 32'h0000_007F, 2'b00);
    txn(0, 0, 32'h0000_0004, 3'b100, 32'h0, 0, 0, 1, 32'h0000_0080, 2'b00);
    txn(0, 0, 32'h0000_0006, 3'b001, 32'h0, 0, 0, 1, 32'hFFFF_8001, 2'b00);
    txn(0, 1, 32'h0000_1005, 3'b000, 32'h0000_01FF, 0, 0, 0, 32'h0, 2'b00);
    txn(0, 0, 32'h0000_1004, 3'b010, 32'h0, 0, 0, 1, 32'hA5A5_FFA5, 2'b00);
    txn(0, 0, 32'h0000_13FC, 3'b010, 32'h0, 0, 0, 1, 32'h0BAD_F00D, 2'b00);
    txn(0, 0, 32'h0000_1400, 3'b010, 32'h0, 0, 0, 1, 32'h0, 2'b01);
    txn(0, 0, 32'h0000_01FC, 3'b010, 32'h0, 0, 0, 1, 32'h0BAD_C0DE, 2'b00);
    txn(0, 0, 32'h0000_0200, 3'b010, 32'h0, 0, 0, 1, 32'h0, 2'b01);

    // Latency-3 instance: back-pressure with competing requests during WAIT/RESPOND.
    txn(1, 1, 32'h0000_1000, 3'b010, 32'hCAFE_F00D, 0, 1, 0, 32'h0, 2'b00);
    txn(1, 0, 32'h0000_1000, 3'b010, 32'h0, 5, 1, 1, 32'hCAFE_F00D, 2'b00);
    txn(1, 1, 32'h0000_1001, 3'b000, 32'h0000_005A, 1, 1, 0, 32'h0, 2'b00);
    txn(1, 0, 32'h0000_1000, 3'b101, 32'h0, 2, 0, 1, 32'h0000_5A0D, 2'b00);
    txn(1, 0, 32'h0000_1003, 3'b010, 32'h0, 3, 1, 1, 32'h0, 2'b10);

    // Reset during WAIT must abort the store.
    req_write[1] = 1'b1; req_address[1] = 32'h0000_1000;
    req_size_and_sign[1] = 3'b010; req_write_data[1] = 32'h1234_5678; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    busy[1] = 1'b1; req_valid[1] = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0; busy[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(1, "rst_mid_resp_valid", 32'(resp_valid[1]), 32'd0);
    chk(1, "rst_mid_req_ready", 32'(req_ready[1]), 32'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;
    txn(1, 0, 32'h0000_1000, 3'b010, 32'h0, 0, 0, 1, 32'hCAFE_5A0D, 2'b00);
    txn(0, 0, 32'h0000_1000, 3'b010, 32'h0, 0, 0, 1, 32'h8001_3344, 2'b00);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/banked_memory_controller.md
Name: banked_memory_controller

Overview:
- Parametrised successor to the CPU's flat ROM+RAM memory: one request/response port in front of a read-only ROM region and a byte-addressable RAM region.
- Adds a valid/ready handshake, configurable access latency, byte-lane writes, correct sign extension and explicit fault reporting (misaligned, unmapped, ROM write).
- Sits between the core's load/store unit (and fetch) and the on-chip storage; one access outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- ROM_BASE, 32'h0000_0000, ROM byte base; must be word aligned.
- ROM_WORDS, 128, ROM depth in 32-bit words; power of two.
- RAM_BASE, 32'h0000_1000, RAM byte base; must be word aligned.
- RAM_WORDS, 256, RAM depth in 32-bit words; power of two.
- ACCESS_LATENCY, 1, cycles spent in WAIT; must be >= 1.
- ROM_INIT_FILE, "rom.hex", hex image loaded into ROM at elaboration.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_address  in  ADDR_WIDTH  byte address.
- req_size_and_sign  in  3  RISC-V funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_write_data  in  32  store data, right-aligned.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_read_data  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  access faulted.
- resp_fault_code  out  2  00 none, 01 unmapped, 10 misaligned/illegal size, 11 write to ROM.

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE, req_ready=1, resp_valid=0, resp_read_data=0, resp_fault=0, resp_fault_code=00, latency counter 0. Storage contents are not reset.
- FSM states: IDLE, WAIT, RESPOND.
- IDLE: req_ready=1. On req_valid&&req_ready, latch write, address, size and data; load counter with ACCESS_LATENCY-1; go to WAIT.
- WAIT: req_ready=0. Decrement the counter each cycle. At counter==0:
  - Perform the access; a store commits on this edge only if no fault.
  - Register data and fault into the resp_* outputs; go to RESPOND.
- RESPOND: resp_valid=1. Outputs stay stable until resp_ready. On resp_valid&&resp_ready, go to IDLE; resp_valid drops on the next cycle.
- Timing: request accepted at edge N gives resp_valid high from edge N+ACCESS_LATENCY. A new request is accepted no sooner than one cycle after the response handshake.
- Decode:
  - ROM hit: ROM_BASE <= addr < ROM_BASE+4*ROM_WORDS.
  - RAM hit: RAM_BASE <= addr < RAM_BASE+4*RAM_WORDS.
  - Neither: unmapped. Region indices use the word offset addr[..:2] minus base.
- Fault priority, highest first:
  - 10: illegal size, i.e. any load code outside the five above, any store code other than 000/001/010, or halfword with addr[0]!=0, or word with addr[1:0]!=0.
  - 01: unmapped.
  - 11: store to ROM.
  - On any fault: read_data=0 and no state is modified.
- Loads: lane = addr[1:0].
  - Byte: word[8*lane+7 : 8*lane], sign- or zero-extended from bit 7.
  - Half: word[16*addr[1]+15 : 16*addr[1]], extended from bit 15.
  - Word: whole word.
  - ROM and RAM both support all sizes.
- Stores (RAM only):
  - Byte: write_data[7:0] replicated to all lanes, byte-enable for lane addr[1:0] only.
  - Half: write_data[15:0] replicated, enables {2{addr[1]}}/{2{~addr[1]}}.
  - Word: all four enables.
- Inputs are ignored outside IDLE; req_* changes after acceptance have no effect.
- Reset asserted in WAIT aborts the access; no partial write.
- Reset asserted in RESPOND discards the response.

Decomposition:
- Shared package (arch_defines): LOAD_*/STORE_* funct3 encodings, FAULT_NONE/UNMAPPED/MISALIGNED/ROM_WRITE codes, FSM state encodings.
- Sub-module ram_bank: RAM_WORDS x 32 synchronous-write array with a 4-bit byte enable and combinational read, instantiated once for RAM.
- ROM is a plain initialised array inside the top module.

Test Plan:
- Reset and ROM load: hold reset_n low then release; assert all outputs at reset values and req_ready=1. With ACCESS_LATENCY=1 and ROM[0]=32'hDEADBEEF, LW @0x0 -> resp_valid one cycle after accept, data 32'hDEADBEEF, fault 00.
- RAM byte path: SB data 32'h0000_0080 @0x1003, then LB @0x1003 -> 32'hFFFF_FF80. LBU -> 32'h0000_0080. LW @0x1000 -> bits [31:24]=8'h80, other lanes unchanged.
- Halfword and misalignment: SH 32'h0000_8001 @0x1002, then LH @0x1002 -> 32'hFFFF_8001 and LHU -> 32'h0000_8001. LH @0x1001 -> fault 10, data 0. LW @0x1002 -> fault 10.
- Fault codes: SW @0x0000 -> fault 11 and ROM[0] unchanged on re-read. LW @0x3000 -> fault 01. Load with size 011 -> fault 10. SH @0x0001 -> fault 10, not 11 (priority).
- Back-pressure and latency: with ACCESS_LATENCY=3, hold resp_ready=0 for 5 cycles; resp_valid appears 3 cycles after accept and data stays stable. A second req_valid during WAIT/RESPOND is not accepted (req_ready=0).
- Reset mid-op: issue SW 32'h12345678 @0x1000, assert reset_n low during WAIT before the counter reaches 0. After release, LW @0x1000 returns the prior contents, and resp_valid was 0 throughout reset.
